// File: rtl/opb_arb_pkg.sv
// Shared types and helpers for the OPB round-robin arbiter.
// Holds the arbiter state encoding, the grant idle limit and the rotating pick function.
package opb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANTED,
    BUSY
  } arb_state_e;

  localparam int MAX_MASTERS      = 4;
  localparam int PTR_W            = 2;
  localparam int GRANT_IDLE_LIMIT = 8;

  // One-hot pick of the first requester at or after ptr, wrapping modulo n.
  function automatic logic [MAX_MASTERS-1:0] rr_pick(
    input logic [MAX_MASTERS-1:0] req,
    input logic [PTR_W-1:0]       ptr,
    input int                     n
  );
    logic [MAX_MASTERS-1:0] pick;
    logic                   found;
    int                     idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_MASTERS; k++) begin
      idx = (int'(ptr) + k) % n;
      if ((k < n) && !found && req[idx[PTR_W-1:0]]) begin
        pick[idx[PTR_W-1:0]] = 1'b1;
        found                = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/opb_arb_tout_cnt.sv
// Bus timeout monitor: counts selected cycles with no slave response and
// emits a single-cycle pulse when the count reaches TOUT_CYCLES.
module opb_arb_tout_cnt #(
  parameter int TOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sel,
  input  logic resp,
  input  logic tout_sup,
  output logic timeout
);

  localparam int CW = $clog2(TOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc;
  logic          counting;

  // A response in the same cycle the count would hit the limit suppresses the pulse.
  always_comb begin
    counting = sel && !resp && !tout_sup;
    cnt_inc  = (cnt_q == CW'(TOUT_CYCLES)) ? cnt_q : cnt_q + CW'(1);
    timeout  = rst_n && counting && (cnt_inc == CW'(TOUT_CYCLES));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!sel || resp || timeout) begin
      cnt_q <= '0;
    end else if (!tout_sup) begin
      cnt_q <= cnt_inc;
    end
  end

endmodule

// File: rtl/opb_rr_arbiter.sv
// Round-robin OPB arbiter: grants one master at a time, muxes its address,
// data and control onto the shared bus, and raises OPB_timeout on silent slaves.
module opb_rr_arbiter
  import opb_arb_pkg::*;
#(
  parameter int NUM_MASTERS  = 2,
  parameter int TOUT_CYCLES  = 16,
  parameter int C_OPB_AWIDTH = 32,
  parameter int C_OPB_DWIDTH = 32
) (
  input  logic                                     OPB_Clk,
  input  logic                                     OPB_Rst_n,
  input  logic [NUM_MASTERS-1:0]                   M_request,
  input  logic [NUM_MASTERS-1:0]                   M_busLock,
  input  logic [NUM_MASTERS-1:0]                   M_select,
  input  logic [NUM_MASTERS-1:0]                   M_RNW,
  input  logic [NUM_MASTERS-1:0]                   M_seqAddr,
  input  logic [0:NUM_MASTERS*C_OPB_AWIDTH-1]      M_ABus,
  input  logic [0:NUM_MASTERS*(C_OPB_DWIDTH/8)-1]  M_BE,
  input  logic [0:NUM_MASTERS*C_OPB_DWIDTH-1]      M_DBus,
  input  logic                                     Sl_xferAck,
  input  logic                                     Sl_retry,
  input  logic                                     Sl_toutSup,
  input  logic                                     Sl_errAck,
  output logic [NUM_MASTERS-1:0]                   OPB_MGrant,
  output logic                                     OPB_select,
  output logic                                     OPB_RNW,
  output logic                                     OPB_seqAddr,
  output logic [0:C_OPB_AWIDTH-1]                  OPB_ABus,
  output logic [0:(C_OPB_DWIDTH/8)-1]              OPB_BE,
  output logic [0:C_OPB_DWIDTH-1]                  OPB_DBus,
  output logic                                     OPB_xferAck,
  output logic                                     OPB_retry,
  output logic                                     OPB_errAck,
  output logic                                     OPB_timeout
);

  localparam int BEW = C_OPB_DWIDTH / 8;

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d, ptr_after;
  logic [3:0]             gidle_q, gidle_d;
  logic [MAX_MASTERS-1:0] req_ext, pick;
  logic                   own_req, own_lock, own_sel;
  logic                   slave_done, any_resp, tout_pulse, drop;

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      gidle_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      gidle_q <= gidle_d;
    end
  end

  // Any release goes through IDLE, which leaves one dead cycle between owners.
  always_comb begin
    req_ext                  = '0;
    req_ext[NUM_MASTERS-1:0] = M_request;
    pick                     = rr_pick(req_ext, ptr_q, NUM_MASTERS);
    own_req                  = |(M_request & grant_q);
    own_lock                 = |(M_busLock & grant_q);
    own_sel                  = |(M_select & grant_q);
    slave_done               = own_sel && (Sl_xferAck || Sl_retry);
    ptr_after                = ptr_q;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        ptr_after = PTR_W'((i + 1) % NUM_MASTERS);
      end
    end

    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    gidle_d = '0;
    drop    = 1'b0;

    case (state_q)
      IDLE: begin
        if (|pick) begin
          grant_d = pick[NUM_MASTERS-1:0];
          state_d = GRANTED;
        end
      end
      GRANTED, BUSY: begin
        if (tout_pulse) begin
          drop = 1'b1;
        end else if (slave_done) begin
          if (own_lock) begin
            state_d = GRANTED;
          end else begin
            drop = 1'b1;
          end
        end else if (state_q == BUSY) begin
          if (!own_sel) begin
            drop = 1'b1;
          end
        end else if (own_sel) begin
          state_d = BUSY;
        end else if (!own_req && !own_lock) begin
          drop = 1'b1;
        end else if (gidle_q == 4'(GRANT_IDLE_LIMIT)) begin
          drop = 1'b1;
        end else begin
          gidle_d = gidle_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    if (drop) begin
      state_d = IDLE;
      grant_d = '0;
      ptr_d   = ptr_after;
    end
  end

  // AND-OR mux keyed by the registered one-hot grant; all zero with no owner.
  always_comb begin
    OPB_select  = 1'b0;
    OPB_RNW     = 1'b0;
    OPB_seqAddr = 1'b0;
    OPB_ABus    = '0;
    OPB_BE      = '0;
    OPB_DBus    = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        OPB_select  = OPB_select  | M_select[i];
        OPB_RNW     = OPB_RNW     | M_RNW[i];
        OPB_seqAddr = OPB_seqAddr | M_seqAddr[i];
        OPB_ABus    = OPB_ABus    | M_ABus[i*C_OPB_AWIDTH +: C_OPB_AWIDTH];
        OPB_BE      = OPB_BE      | M_BE[i*BEW +: BEW];
        OPB_DBus    = OPB_DBus    | M_DBus[i*C_OPB_DWIDTH +: C_OPB_DWIDTH];
      end
    end
  end

  assign OPB_MGrant  = grant_q;
  assign OPB_xferAck = Sl_xferAck;
  assign OPB_retry   = Sl_retry;
  assign OPB_errAck  = Sl_errAck;
  assign any_resp    = Sl_xferAck || Sl_retry || Sl_errAck;
  assign OPB_timeout = tout_pulse;

  opb_arb_tout_cnt #(
    .TOUT_CYCLES(TOUT_CYCLES)
  ) u_tout_cnt (
    .clk     (OPB_Clk),
    .rst_n   (OPB_Rst_n),
    .sel     (OPB_select),
    .resp    (any_resp),
    .tout_sup(Sl_toutSup),
    .timeout (tout_pulse)
  );

endmodule

// File: tb/tb_opb_rr_arbiter.sv
// Directed self-checking bench for opb_rr_arbiter with two masters and TOUT_CYCLES=16.
module tb_opb_rr_arbiter;

  localparam int NM   = 2;
  localparam int TOUT = 16;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic              OPB_Clk = 1'b0;
  logic              OPB_Rst_n;
  logic [NM-1:0]     M_request, M_busLock, M_select, M_RNW, M_seqAddr;
  logic [0:NM*AW-1]  M_ABus;
  logic [0:NM*4-1]   M_BE;
  logic [0:NM*DW-1]  M_DBus;
  logic              Sl_xferAck, Sl_retry, Sl_toutSup, Sl_errAck;
  logic [NM-1:0]     OPB_MGrant;
  logic              OPB_select, OPB_RNW, OPB_seqAddr;
  logic [0:AW-1]     OPB_ABus;
  logic [0:3]        OPB_BE;
  logic [0:DW-1]     OPB_DBus;
  logic              OPB_xferAck, OPB_retry, OPB_errAck, OPB_timeout;

  int checks   = 0;
  int failures = 0;

  opb_rr_arbiter #(
    .NUM_MASTERS (NM),
    .TOUT_CYCLES (TOUT),
    .C_OPB_AWIDTH(AW),
    .C_OPB_DWIDTH(DW)
  ) dut (
    .OPB_Clk    (OPB_Clk),
    .OPB_Rst_n  (OPB_Rst_n),
    .M_request  (M_request),
    .M_busLock  (M_busLock),
    .M_select   (M_select),
    .M_RNW      (M_RNW),
    .M_seqAddr  (M_seqAddr),
    .M_ABus     (M_ABus),
    .M_BE       (M_BE),
    .M_DBus     (M_DBus),
    .Sl_xferAck (Sl_xferAck),
    .Sl_retry   (Sl_retry),
    .Sl_toutSup (Sl_toutSup),
    .Sl_errAck  (Sl_errAck),
    .OPB_MGrant (OPB_MGrant),
    .OPB_select (OPB_select),
    .OPB_RNW    (OPB_RNW),
    .OPB_seqAddr(OPB_seqAddr),
    .OPB_ABus   (OPB_ABus),
    .OPB_BE     (OPB_BE),
    .OPB_DBus   (OPB_DBus),
    .OPB_xferAck(OPB_xferAck),
    .OPB_retry  (OPB_retry),
    .OPB_errAck (OPB_errAck),
    .OPB_timeout(OPB_timeout)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit after that.
  task automatic step();
    @(posedge OPB_Clk);
    #1;
  endtask

  task automatic clear_inputs();
    M_request  = '0;
    M_busLock  = '0;
    M_select   = '0;
    M_RNW      = '0;
    M_seqAddr  = '0;
    M_ABus     = '0;
    M_BE       = '0;
    M_DBus     = '0;
    Sl_xferAck = 1'b0;
    Sl_retry   = 1'b0;
    Sl_toutSup = 1'b0;
    Sl_errAck  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    OPB_Rst_n = 1'b0;
    step();
    step();
    OPB_Rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    OPB_Rst_n = 1'b0;
    M_request = '1;
    M_select  = '1;
    M_ABus    = '1;
    M_DBus    = '1;
    step();
    step();
    #1;
    checks++;
    if (OPB_MGrant !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_grant: got %b expected 00", OPB_MGrant);
    end
    checks++;
    if (OPB_select !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_select: got %b expected 0", OPB_select);
    end
    checks++;
    if (OPB_ABus !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_abus: got %h expected 00000000", OPB_ABus);
    end
    checks++;
    if (OPB_timeout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_timeout: got %b expected 0", OPB_timeout);
    end
    OPB_Rst_n = 1'b1;
    clear_inputs();
  endtask

  task automatic test_single();
    do_reset();
    M_request = 2'b01;
    #1;
    checks++;
    if (OPB_MGrant !== 2'b00) begin
      failures++;
      $display("[TB] FAIL single_no_early_grant: got %b expected 00", OPB_MGrant);
    end
    step();
    checks++;
    if (OPB_MGrant !== 2'b01) begin
      failures++;
      $display("[TB] FAIL single_grant: got %b expected 01", OPB_MGrant);
    end
    M_ABus[0:31]  = 32'h0100_0000;
    M_ABus[32:63] = 32'hBAD0_0000;
    M_DBus[0:31]  = 32'hDEAD_BEEF;
    M_DBus[32:63] = 32'h1234_5678;
    M_BE[0:3]     = 4'hF;
    M_BE[4:7]     = 4'h3;
    M_RNW         = 2'b10;
    M_select      = 2'b10;
    #1;
    checks++;
    if (OPB_select !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_nonowner_select: got %b expected 0", OPB_select);
    end
    step();
    M_select = 2'b01;
    #1;
    checks++;
    if (OPB_select !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_select: got %b expected 1", OPB_select);
    end
    checks++;
    if (OPB_ABus !== 32'h0100_0000) begin
      failures++;
      $display("[TB] FAIL single_abus: got %h expected 01000000", OPB_ABus);
    end
    checks++;
    if (OPB_DBus !== 32'hDEAD_BEEF) begin
      failures++;
      $display("[TB] FAIL single_dbus: got %h expected deadbeef", OPB_DBus);
    end
    checks++;
    if (OPB_BE !== 4'hF || OPB_RNW !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_be_rnw: got %h/%b expected f/0", OPB_BE, OPB_RNW);
    end
    step();
    Sl_xferAck = 1'b1;
    #1;
    checks++;
    if (OPB_xferAck !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_ack_pass: got %b expected 1", OPB_xferAck);
    end
    step();
    clear_inputs();
    #1;
    checks++;
    if (OPB_MGrant !== 2'b00 || OPB_ABus !== 32'h0) begin
      failures++;
      $display("[TB] FAIL single_release: got %b/%h expected 00/00000000", OPB_MGrant, OPB_ABus);
    end
  endtask

  task automatic test_contention();
    logic [NM-1:0] exp_gnt;
    do_reset();
    M_request = 2'b11;
    for (int t = 0; t < 4; t++) begin
      exp_gnt = (t % 2 == 1) ? 2'b10 : 2'b01;
      step();
      checks++;
      if (OPB_MGrant !== exp_gnt) begin
        failures++;
        $display("[TB] FAIL contention_grant%0d: got %b expected %b", t, OPB_MGrant, exp_gnt);
      end
      M_select = exp_gnt;
      step();
      checks++;
      if (OPB_MGrant !== exp_gnt) begin
        failures++;
        $display("[TB] FAIL contention_busy%0d: got %b expected %b", t, OPB_MGrant, exp_gnt);
      end
      Sl_xferAck = 1'b1;
      step();
      Sl_xferAck = 1'b0;
      M_select   = 2'b00;
      #1;
      checks++;
      if (OPB_MGrant !== 2'b00) begin
        failures++;
        $display("[TB] FAIL contention_dead%0d: got %b expected 00", t, OPB_MGrant);
      end
    end
    clear_inputs();
  endtask

  task automatic test_bus_lock();
    logic [NM-1:0] exp_gnt;
    do_reset();
    M_request = 2'b11;
    M_busLock = 2'b01;
    step();
    checks++;
    if (OPB_MGrant !== 2'b01) begin
      failures++;
      $display("[TB] FAIL lock_grant: got %b expected 01", OPB_MGrant);
    end
    M_select = 2'b01;
    for (int k = 0; k < 3; k++) begin
      step();
      Sl_xferAck = 1'b1;
      if (k == 2) M_busLock = 2'b00;
      step();
      Sl_xferAck = 1'b0;
      #1;
      exp_gnt = (k == 2) ? 2'b00 : 2'b01;
      checks++;
      if (OPB_MGrant !== exp_gnt) begin
        failures++;
        $display("[TB] FAIL lock_hold%0d: got %b expected %b", k, OPB_MGrant, exp_gnt);
      end
    end
    M_select  = 2'b00;
    M_request = 2'b10;
    step();
    checks++;
    if (OPB_MGrant !== 2'b10) begin
      failures++;
      $display("[TB] FAIL lock_handover: got %b expected 10", OPB_MGrant);
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    M_request = 2'b01;
    step();
    M_select = 2'b01;
    for (int c = 1; c <= TOUT; c++) begin
      #1;
      checks++;
      if (OPB_timeout !== (c == TOUT)) begin
        failures++;
        $display("[TB] FAIL timeout_cycle%0d: got %b expected %b", c, OPB_timeout, (c == TOUT));
      end
      if (c < TOUT) step();
    end
    step();
    #1;
    checks++;
    if (OPB_MGrant !== 2'b00 || OPB_timeout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_drop: got %b/%b expected 00/0", OPB_MGrant, OPB_timeout);
    end
    M_select = 2'b00;
    step();
    checks++;
    if (OPB_MGrant !== 2'b01) begin
      failures++;
      $display("[TB] FAIL toutsup_grant: got %b expected 01", OPB_MGrant);
    end
    M_select   = 2'b01;
    Sl_toutSup = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      #1;
      checks++;
      if (OPB_timeout !== 1'b0) begin
        failures++;
        $display("[TB] FAIL toutsup_cycle%0d: got %b expected 0", c, OPB_timeout);
      end
      step();
    end
    Sl_toutSup = 1'b0;
    Sl_xferAck = 1'b1;
    #1;
    checks++;
    if (OPB_timeout !== 1'b0 || OPB_MGrant !== 2'b01) begin
      failures++;
      $display("[TB] FAIL toutsup_ack: got %b/%b expected 0/01", OPB_timeout, OPB_MGrant);
    end
    step();
    clear_inputs();
    #1;
    checks++;
    if (OPB_MGrant !== 2'b00) begin
      failures++;
      $display("[TB] FAIL toutsup_release: got %b expected 00", OPB_MGrant);
    end
  endtask

  task automatic test_ack_collision();
    do_reset();
    M_request = 2'b01;
    step();
    M_select = 2'b01;
    for (int c = 1; c < TOUT; c++) step();
    Sl_xferAck = 1'b1;
    #1;
    checks++;
    if (OPB_timeout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL collision_timeout: got %b expected 0", OPB_timeout);
    end
    step();
    clear_inputs();
    #1;
    checks++;
    if (OPB_MGrant !== 2'b00 || OPB_timeout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL collision_release: got %b/%b expected 00/0", OPB_MGrant, OPB_timeout);
    end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    M_request = 2'b01;
    step();
    M_select = 2'b01;
    step();
    Sl_xferAck = 1'b1;
    step();
    Sl_xferAck = 1'b0;
    M_select   = 2'b00;
    M_request  = 2'b10;
    step();
    checks++;
    if (OPB_MGrant !== 2'b10) begin
      failures++;
      $display("[TB] FAIL midrst_grant: got %b expected 10", OPB_MGrant);
    end
    M_select = 2'b10;
    step();
    OPB_Rst_n = 1'b0;
    step();
    #1;
    checks++;
    if (OPB_MGrant !== 2'b00 || OPB_select !== 1'b0 || OPB_timeout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrst_drop: got %b/%b/%b expected 00/0/0", OPB_MGrant, OPB_select, OPB_timeout);
    end
    OPB_Rst_n = 1'b1;
    M_select  = 2'b00;
    M_request = 2'b11;
    step();
    checks++;
    if (OPB_MGrant !== 2'b01) begin
      failures++;
      $display("[TB] FAIL midrst_ptr: got %b expected 01", OPB_MGrant);
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    OPB_Rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_contention();
    test_bus_lock();
    test_timeout();
    test_ack_collision();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/opb_rr_arbiter.md
Name: opb_rr_arbiter

Overview:
- Round-robin OPB bus arbiter and timeout monitor for the shared slave bus.
- That bus carries the ppc2simulink software-register slaves such as the a0/fd0 register at 0x01000000.
- Shares the bus between NUM_MASTERS masters, for example the PPC bridge and an on-fabric config sequencer.
- Muxes the winning master's address, data and control onto the bus, and generates OPB_timeout when no slave responds.

Parameters:
- NUM_MASTERS, 2, number of requesting masters, range 2..4.
- TOUT_CYCLES, 16, select cycles without a response before OPB_timeout fires, range 4..255.
- C_OPB_AWIDTH, 32, address width.
- C_OPB_DWIDTH, 32, data width.

Ports:
- OPB_Clk  in  1  bus clock; the only clock.
- OPB_Rst_n  in  1  synchronous, active-low reset.
- M_request  in  NUM_MASTERS  bus request, one bit per master; bit 0 is master 0.
- M_busLock  in  NUM_MASTERS  master holds grant across transfers.
- M_select  in  NUM_MASTERS  master transfer select.
- M_RNW  in  NUM_MASTERS  read-not-write.
- M_seqAddr  in  NUM_MASTERS  sequential address hint.
- M_ABus  in  NUM_MASTERS*32  concatenated addresses; master 0 in bits [0:31].
- M_BE  in  NUM_MASTERS*4  concatenated byte enables.
- M_DBus  in  NUM_MASTERS*32  concatenated write data.
- Sl_xferAck, Sl_retry, Sl_toutSup, Sl_errAck  in  1 each  ORed slave responses.
- OPB_MGrant  out  NUM_MASTERS  one-hot grant.
- OPB_select, OPB_RNW, OPB_seqAddr  out  1 each  muxed owner control.
- OPB_ABus  out  [0:31]  muxed owner address.
- OPB_BE  out  [0:3]  muxed owner byte enables.
- OPB_DBus  out  [0:31]  muxed owner write data.
- OPB_xferAck, OPB_retry, OPB_errAck  out  1 each  slave responses passed through.
- OPB_timeout  out  1  one-cycle timeout pulse.

Behaviour:
- Reset (OPB_Rst_n=0 at a clock edge):
  - OPB_MGrant=0, rr pointer=0, state IDLE, timeout counter=0, OPB_timeout=0.
  - All muxed outputs are 0 because no owner exists.
- Reset mid-transfer drops the grant on the next edge; the bus goes idle with no timeout pulse.
- States:
  - IDLE: no grant.
  - GRANTED: grant given, owner not yet selecting.
  - BUSY: owner's M_select=1.
- IDLE, with any M_request bit set:
  - Register a one-hot grant to the first requester at or after the rr pointer, wrapping modulo NUM_MASTERS.
  - Grant latency is 1 cycle from request to OPB_MGrant.
  - Next state GRANTED.
- GRANTED:
  - Owner M_select=1 goes to BUSY.
  - Owner drops M_request with busLock=0: grant drops, back to IDLE, rr pointer = owner+1.
  - More than 8 cycles without select, request or lock: revoke the grant (same pointer update).
- BUSY, on Sl_xferAck or Sl_retry:
  - Owner busLock=1: stay GRANTED for the same owner; no re-arbitration.
  - Otherwise drop the grant; rr pointer = owner+1.
  - New grant issues no earlier than the cycle after the grant drops (1 dead cycle), so two OPB_MGrant bits are never high together.
- BUSY, owner deasserts M_select without any response: treat as abort, same as ack with busLock=0.
- Mux: outputs equal the owner's slice while a grant is held; otherwise 0. OPB_select = M_select[owner] AND grant. All mux paths are combinational from the registered grant.
- Non-owner M_select is ignored; it never reaches OPB_select.
- Response pass-through: Sl_* to OPB_* is combinational, zero latency. Sl_toutSup is internal only.
- Timeout:
  - Counter increments each cycle OPB_select=1 with no xferAck, retry or errAck.
  - Counter holds while Sl_toutSup=1 and clears on any response or when select drops.
  - On reaching TOUT_CYCLES: OPB_timeout=1 for exactly one cycle, counter clears, the owner is treated as aborted (grant drop, pointer advance).
  - If a response arrives in the same cycle the count hits TOUT_CYCLES, the response wins and there is no timeout.
- A request from the master that just released is served last if others are waiting; if it is alone, it is re-granted after the dead cycle.
- Width rule: the counter is clog2(TOUT_CYCLES+1) bits and saturates; it never wraps.

Decomposition:
- Shared package opb_arb_pkg holds:
  - the state enum (IDLE/GRANTED/BUSY);
  - GRANT_IDLE_LIMIT = 8;
  - the function rr_pick(req, ptr), returning a one-hot result.
- One sub-module, opb_arb_tout_cnt, holds the timeout counter and pulse.

Test Plan:
- Single request: M_request=01, no lock → OPB_MGrant=01 one cycle later; master 0 select with addr 0x01000000, write 0xDEADBEEF → OPB_ABus/DBus match; xferAck → grant 00 next cycle.
- Contention: M_request=11 held, each transfer acked after 2 cycles → grants alternate 01,00,10,00,01…, never 11.
- Bus lock: master 0 busLock=1 over 3 acked transfers while master 1 requests → grant stays 01 throughout; 10 follows after lock release plus 1 dead cycle.
- Timeout: select held, no slave response, TOUT_CYCLES=16 → OPB_timeout pulses on cycle 16 of select; grant drops. Repeat with Sl_toutSup=1 for 20 cycles, then xferAck → no timeout.
- Ack-timeout collision: xferAck exactly on cycle 16 → OPB_timeout stays 0.
- Reset mid-BUSY: OPB_Rst_n=0 for 1 cycle during a transfer → grant 00 and OPB_select 0 next edge; next request is granted to master 0 (pointer reset).
